// File: rtl/bus_rr_arbiter.sv
// bus_rr_arbiter
//   Round-robin arbiter that shares the system bus among N_MASTER masters.
//   The grant is registered and one-hot. grant_id drives the master-side bus muxes.
//   An owner keeps the bus for at most MAX_HOLD consecutive cycles while another
//   master is requesting. After that, ownership rotates to the next requester.
//
// Parameters
//   N_MASTER  number of requesting masters (2..8)
//   ID_W      width of grant_id, clog2(N_MASTER)
//   MAX_HOLD  max consecutive grant cycles while others wait (1..16)
//
// Ports
//   clk       system clock, rising edge
//   reset     asynchronous, active-high reset
//   req       per-master level request, held until the transfer is done
//   grant     one-hot registered grant; all-zero means the bus is idle
//   grant_id  index of the current owner; holds the last owner while idle
//   busy      high while any grant bit is set
//   hold_cnt  cycles the owner has held the bus in this tenure, 0-based
module bus_rr_arbiter #(
  parameter int N_MASTER = 4,
  parameter int ID_W     = 2,
  parameter int MAX_HOLD = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_MASTER-1:0] req,
  output logic [N_MASTER-1:0] grant,
  output logic [ID_W-1:0]     grant_id,
  output logic                busy,
  output logic [3:0]          hold_cnt
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t                state_reg, state_next;
  logic [N_MASTER-1:0]   grant_reg, grant_next;
  logic [ID_W-1:0]       grant_id_reg, grant_id_next;
  logic [ID_W-1:0]       last_reg, last_next;
  logic [3:0]            hold_reg, hold_next;

  // Round-robin search.
  // While idle, grant_reg is zero, so the mask is just req.
  // While granting, the mask is the set of other requesters.
  // In both cases the search starts just after the last winner.
  logic [N_MASTER-1:0]   search_mask;
  logic [N_MASTER-1:0]   cand_req;
  logic [ID_W-1:0]       cand_id [N_MASTER];
  logic                  rr_found;
  logic [ID_W-1:0]       rr_id;

  assign search_mask = req & ~grant_reg;

  // Candidate gi is the master at distance gi+1 from the pointer, wrapped modulo N_MASTER.
  // The sum needs one extra bit so that the wrap subtraction is exact.
  for (genvar gi = 0; gi < N_MASTER; gi++) begin : g_cand
    logic [ID_W:0] sum;
    assign sum          = {1'b0, last_reg} + (ID_W+1)'(gi + 1);
    assign cand_id[gi]  = (sum >= (ID_W+1)'(N_MASTER))
                          ? ID_W'(sum - (ID_W+1)'(N_MASTER))
                          : sum[ID_W-1:0];
    assign cand_req[gi] = search_mask[cand_id[gi]];
  end

  // Lowest distance wins. The loop scans downward so the nearest requester is assigned last.
  always_comb begin
    rr_found = 1'b0;
    rr_id    = last_reg;
    for (int i = N_MASTER - 1; i >= 0; i--) begin
      if (cand_req[i]) begin
        rr_found = 1'b1;
        rr_id    = cand_id[i];
      end
    end
  end

  logic owner_req;
  logic expire;

  assign owner_req = req[grant_id_reg];
  assign expire    = (hold_reg == 4'(MAX_HOLD - 1));

  always_comb begin
    state_next    = state_reg;
    grant_next    = grant_reg;
    grant_id_next = grant_id_reg;
    last_next     = last_reg;
    hold_next     = hold_reg;
    unique case (state_reg)
      IDLE: begin
        if (rr_found) begin
          state_next    = GRANT;
          grant_next    = N_MASTER'(1) << rr_id;
          grant_id_next = rr_id;
          last_next     = rr_id;
          hold_next     = 4'd0;
        end
      end
      GRANT: begin
        if (owner_req && !expire) begin
          hold_next = hold_reg + 4'd1;
        end else if (rr_found) begin
          // Either the tenure expired or the owner dropped its request.
          // Hand over directly, with no idle cycle in between.
          grant_next    = N_MASTER'(1) << rr_id;
          grant_id_next = rr_id;
          last_next     = rr_id;
          hold_next     = 4'd0;
        end else if (owner_req) begin
          // The tenure expired but nobody else is waiting.
          // Keep the owner and restart the count.
          hold_next = 4'd0;
        end else begin
          state_next = IDLE;
          grant_next = '0;
          hold_next  = 4'd0;
        end
      end
      default: begin
        state_next = IDLE;
        grant_next = '0;
        hold_next  = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      grant_reg    <= '0;
      grant_id_reg <= '0;
      // Point at the highest index so that M0 is searched first after reset.
      last_reg     <= ID_W'(N_MASTER - 1);
      hold_reg     <= 4'd0;
    end else begin
      state_reg    <= state_next;
      grant_reg    <= grant_next;
      grant_id_reg <= grant_id_next;
      last_reg     <= last_next;
      hold_reg     <= hold_next;
    end
  end

  assign grant    = grant_reg;
  assign grant_id = grant_id_reg;
  assign busy     = |grant_reg;
  assign hold_cnt = hold_reg;

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// tb_bus_rr_arbiter
//   Directed bench for bus_rr_arbiter with N_MASTER=4, MAX_HOLD=4 and a 10 ns clock.
//   Inputs change 1 ns after a rising edge, and outputs are sampled at that same point.
module tb_bus_rr_arbiter;

  localparam int N_MASTER = 4;
  localparam int ID_W     = 2;
  localparam int MAX_HOLD = 4;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic [N_MASTER-1:0] req = '0;
  logic [N_MASTER-1:0] grant;
  logic [ID_W-1:0]     grant_id;
  logic                busy;
  logic [3:0]          hold_cnt;

  int checks   = 0;
  int failures = 0;

  bus_rr_arbiter #(
    .N_MASTER (N_MASTER),
    .ID_W     (ID_W),
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .grant    (grant),
    .grant_id (grant_id),
    .busy     (busy),
    .hold_cnt (hold_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Compare every output against one expected bus state.
  task automatic expect_bus(input string tag, input logic [3:0] g, input logic [1:0] id,
                            input logic b, input logic [3:0] h);
    $display("t=%0t %s req=%b grant=%b id=%0d busy=%0b hold=%0d",
             $time, tag, req, grant, grant_id, busy, hold_cnt);
    check({tag, ".grant"},    32'(grant),    32'(g));
    check({tag, ".grant_id"}, 32'(grant_id), 32'(id));
    check({tag, ".busy"},     32'(busy),     32'(b));
    check({tag, ".hold_cnt"}, 32'(hold_cnt), 32'(h));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse reset between edges. This brings the arbiter back to a fresh state with M0 first in line.
  task automatic do_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  initial begin
    int owner;

    // 1: reset held with all masters requesting
    req = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_bus("rst_hold", 4'b0000, 2'd0, 1'b0, 4'd0);
    end
    reset = 1'b0;
    req   = 4'b0000;
    tick();
    expect_bus("idle", 4'b0000, 2'd0, 1'b0, 4'd0);

    // 2: single requester, held 10 cycles; hold_cnt restarts at expiry
    req = 4'b0001;
    for (int i = 0; i < 10; i++) begin
      tick();
      expect_bus("m0_alone", 4'b0001, 2'd0, 1'b1, 4'(i % MAX_HOLD));
    end
    req = 4'b0000;
    tick();
    expect_bus("m0_release", 4'b0000, 2'd0, 1'b0, 4'd0);

    // 3: all request, rotating MAX_HOLD-cycle tenures with wrap to M0
    do_reset();
    req = 4'b1111;
    for (int c = 0; c < 17; c++) begin
      tick();
      owner = (c / MAX_HOLD) % N_MASTER;
      expect_bus("rr_all", 4'(1 << owner), 2'(owner), 1'b1, 4'(c % MAX_HOLD));
    end
    req = 4'b0000;
    tick();
    expect_bus("rr_release", 4'b0000, 2'd0, 1'b0, 4'd0);

    // 4: M0 and M1 request; M0 drops and M1 takes over with no idle cycle
    do_reset();
    req = 4'b0011;
    tick();
    expect_bus("pair_m0_a", 4'b0001, 2'd0, 1'b1, 4'd0);
    tick();
    expect_bus("pair_m0_b", 4'b0001, 2'd0, 1'b1, 4'd1);
    req = 4'b0010;
    tick();
    expect_bus("pair_m1_a", 4'b0010, 2'd1, 1'b1, 4'd0);
    tick();
    expect_bus("pair_m1_b", 4'b0010, 2'd1, 1'b1, 4'd1);
    req = 4'b0000;
    tick();
    expect_bus("pair_release", 4'b0000, 2'd1, 1'b0, 4'd0);

    // 5: M2 alone for 12 cycles, with no forced release
    do_reset();
    req = 4'b0100;
    for (int c = 0; c < 12; c++) begin
      tick();
      expect_bus("m2_alone", 4'b0100, 2'd2, 1'b1, 4'(c % MAX_HOLD));
    end

    // 6: reset while M2 owns the bus, then M1 wins from the reset pointer
    reset = 1'b1;
    #1;
    expect_bus("mid_reset", 4'b0000, 2'd0, 1'b0, 4'd0);
    req = 4'b1010;
    #1;
    reset = 1'b0;
    tick();
    expect_bus("post_reset_a", 4'b0010, 2'd1, 1'b1, 4'd0);
    tick();
    expect_bus("post_reset_b", 4'b0010, 2'd1, 1'b1, 4'd1);
    req = 4'b0000;
    tick();
    expect_bus("post_reset_release", 4'b0000, 2'd1, 1'b0, 4'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
